cordic_seq_ctrl: RTL and testbench

Sequencing controller for the sequential CORDIC unit in the wind-direction datapath. Accepts a start request, latches the operating mode, issues the one-cycle operand load, then steps the arctangent ROM address through every iteration while asserting the datapath iterate enable and the per-iteration rotation direction. Raises a one-cycle done pulse when the result registers are final. It owns the ROM address bus, the datapath load/iterate strobes and the start/done handshake, and holds no arithmetic state.

---
 rtl/cordic_seq_ctrl.sv | 112 +++++++++++
 tb/tb_cordic_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// Sequencing controller for the sequential CORDIC unit: start/done handshake,
// one-cycle operand load, then iterates the arctangent ROM address with rotation direction.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// LOAD  | one-cycle datapath operand load
// ITER  | one micro-rotation per cycle, rom_addr = iteration index
// DONE  | one-cycle done pulse, result final in datapath registers
module cordic_seq_ctrl #(
    parameter int NITER = 16,
    parameter int ADDRW = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             z_sign,
    input  logic             y_sign,
    output logic             ready,
    output logic             busy,
    output logic             load,
    output logic             en_iter,
    output logic [ADDRW-1:0] rom_addr,
    output logic             rot_dir,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NITER - 1);

    state_t           state;
    state_t           state_nx;
    logic [ADDRW-1:0] cnt;
    logic [ADDRW-1:0] cnt_nx;
    logic             mode_r;
    logic             mode_nx;
    logic             at_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_r <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            mode_r <= mode_nx;
        end
    end

    assign at_last = (cnt == LAST_IDX);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode_r;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                // start outranks abort here; abort has nothing to cancel in IDLE
                if (start) begin
                    state_nx = S_LOAD;
                    mode_nx  = mode;
                end
            end
            S_LOAD: begin
                cnt_nx   = '0;
                state_nx = abort ? S_IDLE : S_ITER;
            end
            S_ITER: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (at_last) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ADDRW'(1);
                end
            end
            S_DONE: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Everything except rot_dir decodes registered state only, so no glitches at boundaries.
    assign ready    = (state == S_IDLE);
    assign busy     = (state == S_LOAD) || (state == S_ITER);
    assign load     = (state == S_LOAD);
    assign en_iter  = (state == S_ITER);
    assign rom_addr = (state == S_ITER) ? cnt : '0;
    assign last     = (state == S_ITER) && at_last;
    assign done     = (state == S_DONE);

    // Rotation drives z toward zero; vectoring drives y toward zero.
    assign rot_dir  = (state == S_ITER) && (mode_r ? y_sign : ~z_sign);

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Scoreboard bench for cordic_seq_ctrl: NITER=16 and NITER=1 instances share random stimulus,
// a cycle-position reference model predicts outputs, a monitor compares at the falling edge.
module tb_cordic_seq_ctrl;

    localparam int N0 = 16;
    localparam int N1 = 1;

    logic clock;
    logic reset;
    logic start;
    logic mode;
    logic abort;
    logic z_sign;
    logic y_sign;

    logic       ready0, busy0, load0, en_iter0, rot_dir0, last0, done0;
    logic [3:0] rom_addr0;
    logic       ready1, busy1, load1, en_iter1, rot_dir1, last1, done1;
    logic [3:0] rom_addr1;

    cordic_seq_ctrl #(.NITER(N0), .ADDRW(4)) dut16 (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .z_sign(z_sign), .y_sign(y_sign), .ready(ready0), .busy(busy0), .load(load0),
        .en_iter(en_iter0), .rom_addr(rom_addr0), .rot_dir(rot_dir0), .last(last0), .done(done0)
    );

    cordic_seq_ctrl #(.NITER(N1), .ADDRW(4)) dut1 (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .z_sign(z_sign), .y_sign(y_sign), .ready(ready1), .busy(busy1), .load(load1),
        .en_iter(en_iter1), .rom_addr(rom_addr1), .rot_dir(rot_dir1), .last(last1), .done(done1)
    );

    logic [10:0] act0, act1;
    assign act0 = {ready0, busy0, load0, en_iter0, rom_addr0, rot_dir0, last0, done0};
    assign act1 = {ready1, busy1, load1, en_iter1, rom_addr1, rot_dir1, last1, done1};

    int          niter [2];
    int          pos   [2];   // 0 = idle, k = k cycles after the accepted start edge
    bit          mode_m[2];
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    int          vectors;
    int          miscompares;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [10:0] expect_vec(int n, int p, bit m, bit zs, bit ys);
        logic       r, b, l, e, rd, la, dn;
        logic [3:0] a;
        r  = (p == 0);
        b  = (p >= 1) && (p <= n + 1);
        l  = (p == 1);
        e  = (p >= 2) && (p <= n + 1);
        a  = e ? 4'(p - 2) : 4'd0;
        rd = e ? (m ? ys : !zs) : 1'b0;
        la = (p == n + 1);
        dn = (p == n + 2);
        return {r, b, l, e, a, rd, la, dn};
    endfunction

    // Advance the reference by one clock edge using the inputs held across it.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                pos[d]    = 0;
                mode_m[d] = 1'b0;
            end else if (pos[d] == 0) begin
                if (start) begin
                    pos[d]    = 1;
                    mode_m[d] = mode;
                end
            end else if (pos[d] <= niter[d] + 1) begin
                pos[d] = abort ? 0 : pos[d] + 1;
            end else begin
                pos[d] = 0;
            end
        end
    endtask

    // One cycle: take the edge, drive new inputs, predict this cycle's outputs.
    task automatic step(bit s, bit m, bit a, bit zs, bit ys, bit r, int abort_at, int rst_at);
        @(posedge clock);
        #1;
        model_edge();
        start  = s;
        mode   = m;
        abort  = a | (pos[0] == abort_at);
        z_sign = zs;
        y_sign = ys;
        reset  = r | (pos[0] == rst_at);
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                pos[d]    = 0;
                mode_m[d] = 1'b0;
            end
        end
        q0.push_back(expect_vec(niter[0], pos[0], mode_m[0], z_sign, y_sign));
        q1.push_back(expect_vec(niter[1], pos[1], mode_m[1], z_sign, y_sign));
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(negedge clock);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                vectors++;
                if (act0 !== e)
                    begin
                        miscompares++;
                        $display("FAIL dut16_outputs t=%0t actual=%b required=%b (rdy,bsy,ld,en,addr,dir,last,done)",
                                 $time, act0, e);
                    end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                vectors++;
                if (act1 !== e)
                    begin
                        miscompares++;
                        $display("FAIL dut1_outputs t=%0t actual=%b required=%b (rdy,bsy,ld,en,addr,dir,last,done)",
                                 $time, act1, e);
                    end
            end
        end
    end

    initial begin : driver
        niter[0]    = N0;
        niter[1]    = N1;
        pos[0]      = 0;
        pos[1]      = 0;
        mode_m[0]   = 1'b0;
        mode_m[1]   = 1'b0;
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        abort  = 1'b0;
        z_sign = 1'b0;
        y_sign = 1'b0;

        repeat (3) step(1, 0, 0, 0, 0, 1, -1, -1);
        repeat (2) step(0, 0, 0, 0, 0, 0, -1, -1);

        // rotation with z_sign toggling each cycle, mode wiggled after sampling
        step(1, 0, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 22; i++) step(0, rb(), 0, i[0], rb(), 0, -1, -1);

        // vectoring with alternating y_sign, start pulses while busy
        step(1, 1, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 22; i++) step((i % 5 == 2) && (i < 15), rb(), 0, rb(), !i[0], 0, -1, -1);

        // abort at i=5, then abort during DONE
        step(1, 0, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, rb(), rb(), 0, 7, -1);
        step(1, 1, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 22; i++) step(0, 0, 0, rb(), rb(), 0, N0 + 2, -1);

        // asynchronous reset mid-iteration at i=7, then a full clean run
        step(1, 0, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, rb(), rb(), 0, -1, 9);
        for (int i = 0; i < 24; i++) step(i == 2, rb(), 0, rb(), rb(), 0, -1, -1);

        // start held high: back-to-back runs
        for (int i = 0; i < 80; i++) step(1, rb(), 0, rb(), rb(), 0, -1, -1);

        // random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 4, rb(), $urandom_range(0, 39) == 0, rb(), rb(),
                 $urandom_range(0, 199) == 0, -1, -1);

        repeat (24) step(0, 0, 0, 0, 0, 0, -1, -1);
        @(negedge clock);
        #1;
        vectors++;
        if (q0.size() + q1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain actual=%0d required=0 pending", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
